// File: rtl/b10_stim_player.sv
// Stimulus sequencer for the b10 controller: plays a loadable opcode program one step per clock
// and compresses the b10 response of observed steps into a 16-bit MISR signature.
module b10_stim_player #(
  parameter int          DEPTH = 32,
  parameter int          AW    = 5,
  parameter logic [15:0] SEED  = 16'hFFFF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [11:0]   wr_data,
  input  logic [AW:0]   prog_len,
  input  logic          go,
  input  logic          abort,
  input  logic          cts,
  input  logic          ctr,
  input  logic [3:0]    v_out,
  output logic          r_button,
  output logic          g_button,
  output logic          key,
  output logic          start,
  output logic          test,
  output logic          rts,
  output logic          rtr,
  output logic [3:0]    v_in,
  output logic          obs,
  output logic          busy,
  output logic          done,
  output logic [15:0]   signature,
  output logic [AW:0]   step_count
);

  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_RUN   = 2'd1;
  localparam logic [1:0]  S_DONE  = 2'd2;
  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] L_ONE   = (AW+1)'(1);

  logic [11:0] r_ram [DEPTH];

  logic [1:0]  r_state;
  logic [AW:0] r_pc;
  logic [AW:0] r_len;
  logic [AW:0] r_step;
  logic [11:0] r_op;
  logic        r_active;
  logic [15:0] r_sig;

  logic        w_wr;
  logic [AW:0] w_len;
  logic [5:0]  w_resp;
  logic [15:0] w_sig_next;
  logic [11:0] w_fetch;

  // Program memory is not reset so a loaded program survives a reset pulse.
  assign w_wr = wr_en && (r_state != S_RUN);

  always_ff @(posedge clock) begin
    if (w_wr) begin
      r_ram[wr_addr] <= wr_data;
    end
  end

  assign w_len      = (prog_len > L_DEPTH) ? L_DEPTH : prog_len;
  assign w_resp     = {ctr, cts, v_out};
  assign w_sig_next = {r_sig[14:0], 1'b0} ^ (r_sig[15] ? 16'h100B : 16'h0000) ^ {10'b0, w_resp};
  assign w_fetch    = r_ram[r_pc[AW-1:0]];

  // r_active marks that r_op holds a real step whose response is captured on the next edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_len    <= '0;
      r_step   <= '0;
      r_op     <= '0;
      r_active <= 1'b0;
      r_sig    <= SEED;
    end else if (abort) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_active <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (go) begin
            r_sig    <= SEED;
            r_step   <= '0;
            r_pc     <= '0;
            r_len    <= w_len;
            r_op     <= '0;
            r_active <= 1'b0;
            r_state  <= (w_len == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (r_active) begin
            r_step <= r_step + L_ONE;
            if (r_op[11]) begin
              r_sig <= w_sig_next;
            end
          end
          if (r_pc < r_len) begin
            r_op     <= w_fetch;
            r_active <= 1'b1;
            r_pc     <= r_pc + L_ONE;
          end else begin
            r_op     <= '0;
            r_active <= 1'b0;
            r_state  <= S_DONE;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_op     <= '0;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign r_button   = r_op[0];
  assign g_button   = r_op[1];
  assign key        = r_op[2];
  assign start      = r_op[3];
  assign test       = r_op[4];
  assign rts        = r_op[5];
  assign rtr        = r_op[6];
  assign v_in       = r_op[10:7];
  assign obs        = r_op[11];
  assign busy       = (r_state == S_RUN);
  assign done       = (r_state == S_DONE);
  assign signature  = r_sig;
  assign step_count = r_step;

endmodule

// File: tb/tb_b10_stim_player.sv
// Directed bench for b10_stim_player: program loads, playback timing, MISR values,
// length saturation, abort, write protection during playback and reset mid-run.
module tb_b10_stim_player;

  logic        clock;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [11:0] wr_data;
  logic [5:0]  prog_len;
  logic        go;
  logic        abort;
  logic        cts;
  logic        ctr;
  logic [3:0]  v_out;
  logic        r_button, g_button, key, start, test, rts, rtr, obs, busy, done;
  logic [3:0]  v_in;
  logic [15:0] signature;
  logic [5:0]  step_count;
  logic [11:0] w_stim;

  int n_checks;
  int n_errors;

  b10_stim_player #(.DEPTH(32), .AW(5), .SEED(16'hFFFF)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .prog_len(prog_len), .go(go), .abort(abort), .cts(cts), .ctr(ctr), .v_out(v_out),
    .r_button(r_button), .g_button(g_button), .key(key), .start(start), .test(test),
    .rts(rts), .rtr(rtr), .v_in(v_in), .obs(obs), .busy(busy), .done(done),
    .signature(signature), .step_count(step_count)
  );

  assign w_stim = {obs, v_in, rtr, rts, test, start, key, g_button, r_button};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_op(input logic [4:0] a, input logic [11:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic set_resp(input logic [5:0] r);
    {ctr, cts, v_out} = r;
  endtask

  task automatic start_run(input logic [5:0] len);
    $display("run start prog_len=%0d", len);
    prog_len = len; go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  initial begin
    int cyc;
    int hits;
    n_checks = 0; n_errors = 0;
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; prog_len = '0;
    go = 1'b0; abort = 1'b0; cts = 1'b0; ctr = 1'b0; v_out = '0;
    tick(); tick();
    reset = 1'b1;
    tick();
    check_val("rst_stim", 32'(w_stim), 32'h000);
    check_val("rst_busy", 32'(busy), 32'h0);
    check_val("rst_done", 32'(done), 32'h0);
    check_val("rst_sig", 32'(signature), 32'hFFFF);
    check_val("rst_step", 32'(step_count), 32'h0);

    // Single observed step, zero response
    write_op(5'd0, 12'h800);
    set_resp(6'h00);
    start_run(6'd1);
    check_val("t1_busy", 32'(busy), 32'h1);
    check_val("t1_stim_e0", 32'(w_stim), 32'h000);
    tick();
    check_val("t1_stim", 32'(w_stim), 32'h800);
    check_val("t1_done_early", 32'(done), 32'h0);
    tick();
    check_val("t1_done", 32'(done), 32'h1);
    check_val("t1_busy_end", 32'(busy), 32'h0);
    check_val("t1_stim_end", 32'(w_stim), 32'h000);
    check_val("t1_sig", 32'(signature), 32'hEFF5);
    check_val("t1_step", 32'(step_count), 32'h1);
    $display("run end sig=%h steps=%0d", signature, step_count);

    // Same step, all-ones response, restarted from DONE
    set_resp(6'h3F);
    start_run(6'd1);
    tick(); tick();
    check_val("t2_sig", 32'(signature), 32'hEFCA);
    check_val("t2_done", 32'(done), 32'h1);
    $display("run end sig=%h steps=%0d", signature, step_count);

    // Four-step program; only step 2 is observed
    write_op(5'd0, 12'h00F);
    write_op(5'd1, 12'h7F0);
    write_op(5'd2, 12'h801);
    write_op(5'd3, 12'h000);
    set_resp(6'h15);
    start_run(6'd4);
    tick();
    check_val("t3_c1", 32'(w_stim), 32'h00F);
    tick();
    check_val("t3_c2", 32'(w_stim), 32'h7F0);
    tick();
    check_val("t3_c3", 32'(w_stim), 32'h801);
    set_resp(6'h2A);
    tick();
    check_val("t3_c4", 32'(w_stim), 32'h000);
    set_resp(6'h15);
    tick();
    check_val("t3_done", 32'(done), 32'h1);
    check_val("t3_sig", 32'(signature), 32'hEFDF);
    check_val("t3_step", 32'(step_count), 32'h4);
    $display("run end sig=%h steps=%0d", signature, step_count);

    // Zero-length run
    start_run(6'd0);
    check_val("t4_done", 32'(done), 32'h1);
    check_val("t4_busy", 32'(busy), 32'h0);
    check_val("t4_stim", 32'(w_stim), 32'h000);
    check_val("t4_sig", 32'(signature), 32'hFFFF);
    check_val("t4_step", 32'(step_count), 32'h0);
    tick();
    check_val("t4_stim_hold", 32'(w_stim), 32'h000);

    // Length saturation: 40 requested, 32 played
    for (int k = 0; k < 32; k++) write_op(5'(k), 12'h001);
    start_run(6'd40);
    cyc = 0; hits = 0;
    while (!done && cyc < 100) begin
      if (r_button) hits++;
      tick();
      cyc++;
    end
    check_val("t5_done", 32'(done), 32'h1);
    check_val("t5_pulses", 32'(hits), 32'd32);
    check_val("t5_step", 32'(step_count), 32'd32);
    check_val("t5_sig", 32'(signature), 32'hFFFF);
    $display("run end sig=%h steps=%0d", signature, step_count);

    // Abort during step 3, with a write attempt during playback
    for (int k = 0; k < 8; k++) write_op(5'(k), 12'h900 | 12'(k));
    set_resp(6'h00);
    start_run(6'd8);
    tick();
    tick();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 12'hABC;
    tick();
    wr_en = 1'b0;
    check_val("t6_s2", 32'(w_stim), 32'h902);
    tick();
    check_val("t6_s3", 32'(w_stim), 32'h903);
    check_val("t6_step3", 32'(step_count), 32'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_val("t6_ab_busy", 32'(busy), 32'h0);
    check_val("t6_ab_done", 32'(done), 32'h0);
    check_val("t6_ab_stim", 32'(w_stim), 32'h000);
    check_val("t6_ab_step", 32'(step_count), 32'd3);
    check_val("t6_ab_sig", 32'(signature), 32'h8FC9);
    tick();
    check_val("t6_idle_busy", 32'(busy), 32'h0);
    check_val("t6_idle_step", 32'(step_count), 32'd3);
    $display("run aborted sig=%h steps=%0d", signature, step_count);

    // Replay proves the write during RUN was dropped
    start_run(6'd8);
    for (int k = 0; k < 6; k++) begin
      tick();
      check_val("t7_replay", 32'(w_stim), 32'h900 | 32'(k));
    end

    // Asynchronous reset in the middle of the run
    reset = 1'b0;
    #1;
    check_val("t8_rst_stim", 32'(w_stim), 32'h000);
    check_val("t8_rst_busy", 32'(busy), 32'h0);
    check_val("t8_rst_sig", 32'(signature), 32'hFFFF);
    check_val("t8_rst_step", 32'(step_count), 32'h0);
    #1;
    reset = 1'b1;
    tick();
    start_run(6'd8);
    tick();
    check_val("t8_ram0", 32'(w_stim), 32'h900);
    for (int k = 1; k < 6; k++) tick();
    check_val("t8_ram5", 32'(w_stim), 32'h905);
    cyc = 0;
    while (!done && cyc < 50) begin
      tick();
      cyc++;
    end
    check_val("t8_done", 32'(done), 32'h1);
    check_val("t8_step", 32'(step_count), 32'd8);
    $display("run end sig=%h steps=%0d", signature, step_count);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

endmodule
